// File: rtl/dsp_be_mlse_isi_emu.sv
// dsp_be_mlse_isi_emu: transmit-side stimulus source for the MLSE backend.
// A parallel PRBS31 generator (x^31+x^28+1, PrllRank bits per step) feeds a
// 3-tap ISI channel (pre/main/post cursor). The block emits saturated signed
// samples plus the aligned reference bits under valid/ready flow control.
//
// Optional build macro: DSP_BE_MLSE_ISI_EMU_NOISE_EN adds uniform {-2..+1} LSB
// noise from an independent PRBS23 before saturation.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_en                 enable word generation
//   i_load_seed, i_seed  load PRBS31 seed and flush the pipeline (highest priority)
//   i_coef_pre/main/pst  signed cursor coefficients for d[k+1], d[k], d[k-1]
//   i_ready              downstream accepts the current word
//   o_valid              o_sample / o_drx_ref hold a valid word
//   o_sample             PrllRank signed samples, lane 0 in the low bits
//   o_drx_ref            transmitted bits aligned to o_sample
module dsp_be_mlse_isi_emu #(
  parameter int unsigned PrllRank    = 16,
  parameter int unsigned SampleWidth = 8,
  parameter int unsigned CoefWidth   = 6
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic                              i_load_seed,
  input  logic [30:0]                       i_seed,
  input  logic signed [CoefWidth-1:0]       i_coef_pre,
  input  logic signed [CoefWidth-1:0]       i_coef_main,
  input  logic signed [CoefWidth-1:0]       i_coef_pst,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic [PrllRank*SampleWidth-1:0]   o_sample,
  output logic [PrllRank-1:0]               o_drx_ref
);

  localparam int unsigned SumW = CoefWidth + 2;
  localparam int unsigned CmpW = ((SumW > SampleWidth) ? SumW : SampleWidth) + 1;
  localparam logic signed [CmpW-1:0] SatMax = CmpW'((2 ** (SampleWidth - 1)) - 1);
  localparam logic signed [CmpW-1:0] SatMin = -SatMax - CmpW'(1);

  typedef enum logic [1:0] {StEmpty, StPrime, StRun} state_e;

  state_e              state_q, state_d;
  logic [30:0]         lfsr_q, lfsr_d;
  logic [PrllRank-1:0] cur_q, cur_d;
  logic [PrllRank-1:0] nxt_q, nxt_d;
  logic                prv_last_q, prv_last_d;

  logic [PrllRank-1:0] gen_word;
  logic [30:0]         gen_lfsr;
  logic                fire;

  logic [PrllRank*SampleWidth-1:0] smp_flat;

  assign o_valid   = (state_q == StRun);
  assign fire      = o_valid & i_ready;
  assign o_drx_ref = o_valid ? cur_q : '0;
  assign o_sample  = o_valid ? smp_flat : '0;

  // Unrolled PRBS31: s[0] is the newest bit, lane j takes the j-th new bit.
  always_comb begin
    logic [30:0] s;
    logic        fb;
    s        = lfsr_q;
    gen_word = '0;
    for (int j = 0; j < int'(PrllRank); j++) begin
      fb          = s[30] ^ s[27];
      gen_word[j] = fb;
      s           = {s[29:0], fb};
    end
    gen_lfsr = s;
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    prv_last_d = prv_last_q;
    if (i_load_seed) begin
      lfsr_d     = (i_seed == '0) ? '1 : i_seed;
      cur_d      = '0;
      nxt_d      = '0;
      prv_last_d = 1'b0;
      state_d    = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (i_en) begin
            nxt_d   = gen_word;
            lfsr_d  = gen_lfsr;
            state_d = StPrime;
          end
        end
        StPrime: begin
          if (i_en) begin
            cur_d   = nxt_q;
            nxt_d   = gen_word;
            lfsr_d  = gen_lfsr;
            state_d = StRun;
          end
        end
        StRun: begin
          if (i_ready) begin
            prv_last_d = cur_q[PrllRank-1];
            if (i_en) begin
              cur_d  = nxt_q;
              nxt_d  = gen_word;
              lfsr_d = gen_lfsr;
            end else begin
              // nxt is kept; PRIME promotes it once enabled again
              state_d = StPrime;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StEmpty;
      lfsr_q     <= '1;
      cur_q      <= '0;
      nxt_q      <= '0;
      prv_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      prv_last_q <= prv_last_d;
    end
  end

`ifdef DSP_BE_MLSE_ISI_EMU_NOISE_EN
  logic [22:0]           noise_q, noise_d;
  logic [2*PrllRank-1:0] noise_bits;

  // PRBS23 (x^23+x^18+1), two bits per lane, advanced only on a fire.
  always_comb begin
    logic [22:0] s;
    logic        fb;
    s          = noise_q;
    noise_bits = '0;
    for (int i = 0; i < 2 * int'(PrllRank); i++) begin
      fb            = s[22] ^ s[17];
      noise_bits[i] = fb;
      s             = {s[21:0], fb};
    end
    noise_d = fire ? s : noise_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      noise_q <= '1;
    end else begin
      noise_q <= noise_d;
    end
  end
`endif

  // ISI sum per lane; bit 1 -> +coef, bit 0 -> -coef.
  always_comb begin
    logic [PrllRank+1:0]      ext;
    logic signed [SumW-1:0]   pre_x, main_x, pst_x, sum;
    logic signed [CmpW-1:0]   acc;
    logic [SampleWidth-1:0]   smp;
    pre_x    = {{2{i_coef_pre[CoefWidth-1]}}, i_coef_pre};
    main_x   = {{2{i_coef_main[CoefWidth-1]}}, i_coef_main};
    pst_x    = {{2{i_coef_pst[CoefWidth-1]}}, i_coef_pst};
    // ext[j] = d[k-1], ext[j+1] = d[k], ext[j+2] = d[k+1] for lane j
    ext      = {nxt_q[0], cur_q, prv_last_q};
    smp_flat = '0;
    for (int j = 0; j < int'(PrllRank); j++) begin
      sum = (ext[j+2] ? pre_x : -pre_x) + (ext[j+1] ? main_x : -main_x)
          + (ext[j] ? pst_x : -pst_x);
      acc = {{(CmpW - SumW){sum[SumW-1]}}, sum};
`ifdef DSP_BE_MLSE_ISI_EMU_NOISE_EN
      acc = acc + {{(CmpW - 1){noise_bits[2*j+1]}}, noise_bits[2*j]};
`endif
      if (acc > SatMax) begin
        smp = SatMax[SampleWidth-1:0];
      end else if (acc < SatMin) begin
        smp = SatMin[SampleWidth-1:0];
      end else begin
        smp = acc[SampleWidth-1:0];
      end
      smp_flat[j*SampleWidth +: SampleWidth] = smp;
    end
  end

endmodule

// File: tb/tb_dsp_be_mlse_isi_emu.sv
// Self-checking bench for dsp_be_mlse_isi_emu. A second instance with
// SampleWidth=6 and coefficients 31/31/31 exercises saturation on the same
// bit stream. The reference keeps the PRBS31 stream as a bit history and a
// word-buffer occupancy count (0 empty, 1 primed, 2 running).
module tb_dsp_be_mlse_isi_emu;

  localparam int P   = 16;
  localparam int SW  = 8;
  localparam int CW  = 6;
  localparam int SW6 = 6;
  localparam logic signed [CW-1:0] C31 = 6'sd31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en, load_seed, ready;
  logic [30:0]          seed;
  logic signed [CW-1:0] c_pre, c_main, c_pst;
  logic                 valid, valid6;
  logic [P*SW-1:0]      sample;
  logic [P*SW6-1:0]     sample6;
  logic [P-1:0]         drx, drx6;

  dsp_be_mlse_isi_emu #(.PrllRank(P), .SampleWidth(SW), .CoefWidth(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load_seed(load_seed), .i_seed(seed),
    .i_coef_pre(c_pre), .i_coef_main(c_main), .i_coef_pst(c_pst), .i_ready(ready),
    .o_valid(valid), .o_sample(sample), .o_drx_ref(drx)
  );

  dsp_be_mlse_isi_emu #(.PrllRank(P), .SampleWidth(SW6), .CoefWidth(CW)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load_seed(load_seed), .i_seed(seed),
    .i_coef_pre(C31), .i_coef_main(C31), .i_coef_pst(C31), .i_ready(ready),
    .o_valid(valid6), .o_sample(sample6), .o_drx_ref(drx6)
  );

  int checks = 0;
  int errors = 0;
  bit hist[$];
  int k;
  int buff;

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // hist[i] holds x[i-31]; seed bit m is x[-1-m].
  function automatic void restart(input logic [30:0] s);
    hist.delete();
    for (int i = 30; i >= 0; i--) hist.push_back(s[i]);
    k = 0;
  endfunction

  // x[n] = x[n-31] ^ x[n-28]
  function automatic bit get_bit(input int n);
    int m;
    while (hist.size() <= n + 31) begin
      m = hist.size();
      hist.push_back(hist[m-31] ^ hist[m-28]);
    end
    return hist[n+31];
  endfunction

  function automatic int lane_val(input int idx, input int pre, input int mn,
                                  input int pst, input int sw);
    bit dm, dc, dp;
    int s, hi, lo;
    dm = (idx == 0) ? 1'b0 : get_bit(idx - 1);
    dc = get_bit(idx);
    dp = get_bit(idx + 1);
    s  = (dp ? pre : -pre) + (dc ? mn : -mn) + (dm ? pst : -pst);
    hi = (1 << (sw - 1)) - 1;
    lo = -(1 << (sw - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic logic [127:0] exp_samples(input int sw, input int pre,
                                               input int mn, input int pst);
    logic [127:0] v;
    logic [31:0]  t;
    v = '0;
    for (int j = 0; j < P; j++) begin
      t = 32'(lane_val(k * P + j, pre, mn, pst, sw));
      for (int b = 0; b < sw; b++) v[j*sw+b] = t[b];
    end
    return v;
  endfunction

  function automatic logic [127:0] exp_drx();
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < P; j++) v[j] = get_bit(k * P + j);
    return v;
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (buff == 2);
    check_eq("valid", 128'(valid), 128'(ev));
    check_eq("valid6", 128'(valid6), 128'(ev));
    if (ev) begin
      check_eq("drx_ref", 128'(drx), exp_drx());
      check_eq("sample", 128'(sample), exp_samples(SW, c_pre, c_main, c_pst));
      check_eq("sample_sat6", 128'(sample6), exp_samples(SW6, 31, 31, 31));
    end else begin
      check_eq("idle_sample", 128'(sample), 128'(0));
      check_eq("idle_drx", 128'(drx), 128'(0));
    end
  endtask

  function automatic void advance();
    if (rst) begin
      buff = 0;
      restart('1);
    end else if (load_seed) begin
      buff = 0;
      restart((seed == '0) ? 31'h7FFF_FFFF : seed);
    end else begin
      case (buff)
        0: if (en) buff = 1;
        1: if (en) buff = 2;
        default: begin
          if (ready) begin
            k++;
            if (!en) buff = 1;
          end
        end
      endcase
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; load_seed = 1'b0; seed = '0;
    c_pre = 6'sd0; c_main = 6'sd10; c_pst = 6'sd0;
    buff = 0;
    restart('1);
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // fill from reset, then a long noiseless main-cursor run
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    repeat (1002) cycle();

    // reload and switch to a full 3-tap channel while empty
    load_seed = 1'b1; seed = 31'($urandom);
    cycle();
    load_seed = 1'b0;
    c_pre = 6'sd2; c_main = 6'sd10; c_pst = 6'sd3;
    repeat (200) cycle();

    // five-cycle stall mid-run
    ready = 1'b0;
    repeat (5) cycle();
    ready = 1'b1;
    repeat (20) cycle();

    // zero seed mid-run behaves as all-ones
    load_seed = 1'b1; seed = '0;
    cycle();
    load_seed = 1'b0;
    repeat (50) cycle();

    // randomized flow control, reloads, resets and coefficients
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      load_seed = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      if (load_seed) begin
        c_pre  = 6'($urandom);
        c_main = 6'($urandom);
        c_pst  = 6'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
